trace_axis_fifo: RTL and testbench

//   Sits directly downstream of continuous_monitoring_system's M_AXIS output; buffers {pc, instr} trace packets ahead of the DMA.

---
 rtl/trace_axis_fifo.sv | 103 ++++++++++
 tb/tb_trace_axis_fifo.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/trace_axis_fifo.sv
// Trace packet FIFO between the monitor's AXI-Stream output and the DMA (first-word-fall-through).
// Optional macro TRACE_AXIS_FIFO_DROP_ON_FULL_EN: never backpressure; drop beats at full and count them.
module trace_axis_fifo #(
   parameter int DATA_WIDTH = 96,
   parameter int DEPTH      = 64,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       S_AXIS_tvalid,
   output logic                       S_AXIS_tready,
   input  logic [DATA_WIDTH-1:0]      S_AXIS_tdata,
   input  logic                       S_AXIS_tlast,
   output logic                       M_AXIS_tvalid,
   input  logic                       M_AXIS_tready,
   output logic [DATA_WIDTH-1:0]      M_AXIS_tdata,
   output logic                       M_AXIS_tlast,
   output logic [$clog2(DEPTH):0]     level,
   output logic [CNT_WIDTH-1:0]       pkt_count,
   output logic [CNT_WIDTH-1:0]       drop_count,
   input  logic                       clear
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

   logic [DATA_WIDTH:0] mem [DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [LW-1:0]       level_q;
   logic                flush;
   logic                full;
   logic                push;
   logic                pop;

   assign flush         = rst | clear;
   assign full          = (level_q == FULL_LEVEL);
   assign M_AXIS_tvalid = (level_q != '0);
   assign pop           = M_AXIS_tvalid & M_AXIS_tready;
   assign {M_AXIS_tlast, M_AXIS_tdata} = mem[rd_ptr];
   assign level         = level_q;

`ifdef TRACE_AXIS_FIFO_DROP_ON_FULL_EN
   logic drop;

   // Ready never depends on the pop, so a beat arriving at full is dropped even if the head leaves.
   assign S_AXIS_tready = 1'b1;
   assign push          = S_AXIS_tvalid & ~full;
   assign drop          = S_AXIS_tvalid & full;

   always_ff @(posedge clk) begin
      if (flush) begin
         drop_count <= '0;
      end else if (drop && drop_count != '1) begin
         drop_count <= drop_count + 1'b1;
      end
   end
`else
   assign S_AXIS_tready = ~full;
   assign push          = S_AXIS_tvalid & S_AXIS_tready;
   assign drop_count    = '0;
`endif

   // Storage is not reset; tdata/tlast are only meaningful while tvalid is high.
   always_ff @(posedge clk) begin
      if (!flush) begin
         if (push) begin
            mem[wr_ptr] <= {S_AXIS_tlast, S_AXIS_tdata};
         end
`ifdef TRACE_AXIS_FIFO_DROP_ON_FULL_EN
         if (drop && S_AXIS_tlast) begin
            mem[wr_ptr - 1'b1][DATA_WIDTH] <= 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level_q   <= '0;
         pkt_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (pop && M_AXIS_tlast) begin
            pkt_count <= pkt_count + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: tb/tb_trace_axis_fifo.sv
// Randomized bench for trace_axis_fifo, checked against a queue-based model of the FIFO.
module tb_trace_axis_fifo;

   localparam int DW    = 96;
   localparam int DEPTH = 64;
   localparam int CW    = 32;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          s_last;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic [LW-1:0] level;
   logic [CW-1:0] pkt_count;
   logic [CW-1:0] drop_count;
   logic          clear;

   int test_count = 0;
   int fail_count = 0;

   logic [DW:0]   model_q[$];
   logic [CW-1:0] model_pkt;
   logic [CW-1:0] model_drop;

   trace_axis_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
      .clk           (clk),
      .rst           (rst),
      .S_AXIS_tvalid (s_valid),
      .S_AXIS_tready (s_ready),
      .S_AXIS_tdata  (s_data),
      .S_AXIS_tlast  (s_last),
      .M_AXIS_tvalid (m_valid),
      .M_AXIS_tready (m_ready),
      .M_AXIS_tdata  (m_data),
      .M_AXIS_tlast  (m_last),
      .level         (level),
      .pkt_count     (pkt_count),
      .drop_count    (drop_count),
      .clear         (clear)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      test_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   function automatic logic [DW-1:0] randData();
      return {$urandom, $urandom, $urandom};
   endfunction

   // Drive one cycle of inputs, compare against the model mid-cycle, then advance the model.
   task automatic applyStimulus(input logic sv, input logic [DW-1:0] sd, input logic sl,
                                input logic mr, input logic cl);
      bit         full_now;
      bit         do_push;
      bit         do_pop;
      bit         do_drop;
      logic [DW:0] tail;
      s_valid = sv;
      s_data  = sd;
      s_last  = sl;
      m_ready = mr;
      clear   = cl;
      @(negedge clk);
      full_now = (model_q.size() == DEPTH);
      checkOutput("level", 128'(level), 128'(model_q.size()));
      checkOutput("m_valid", 128'(m_valid), 128'(model_q.size() != 0));
`ifdef TRACE_AXIS_FIFO_DROP_ON_FULL_EN
      checkOutput("s_ready", 128'(s_ready), 128'(1));
`else
      checkOutput("s_ready", 128'(s_ready), 128'(!full_now));
`endif
      checkOutput("pkt_count", 128'(pkt_count), 128'(model_pkt));
      checkOutput("drop_count", 128'(drop_count), 128'(model_drop));
      if (model_q.size() != 0) begin
         checkOutput("head", 128'({m_last, m_data}), 128'(model_q[0]));
      end
      if (rst || cl) begin
         model_q.delete();
         model_pkt  = '0;
         model_drop = '0;
      end else begin
         do_pop  = (model_q.size() != 0) && mr;
         do_push = sv && !full_now;
`ifdef TRACE_AXIS_FIFO_DROP_ON_FULL_EN
         do_drop = sv && full_now;
`else
         do_drop = 1'b0;
`endif
         if (do_pop) begin
            if (model_q[0][DW]) model_pkt = model_pkt + 1'b1;
            void'(model_q.pop_front());
         end
         if (do_drop) begin
            if (model_drop != '1) model_drop = model_drop + 1'b1;
            if (sl) begin
               tail = model_q[model_q.size() - 1];
               tail[DW] = 1'b1;
               model_q[model_q.size() - 1] = tail;
            end
         end
         if (do_push) model_q.push_back({sl, sd});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic fill(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, randData(), ($urandom_range(0, 3) == 0), 1'b0, 1'b0);
   endtask

   initial begin
      rst     = 1'b1;
      clear   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
      m_ready = 1'b0;
      model_pkt  = '0;
      model_drop = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Three trace beats held while the DMA stalls; head must be pc 0x1000.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, {64'h1000 + 64'(4 * i), $urandom}, 1'b0, 1'b0, 1'b0);
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("head_pc", 128'(m_data[DW-1:32]), 128'(64'h1000));
      drain(4);

      // Fill completely, hold one extra offered beat, then drain in order.
      fill(DEPTH);
      applyStimulus(1'b1, randData(), 1'b0, 1'b0, 1'b0);
      drain(DEPTH + 2);

      // Full with simultaneous offer and pop.
      fill(DEPTH);
      applyStimulus(1'b1, randData(), 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      drain(DEPTH + 1);

      // Single tlast beat through an empty FIFO with the DMA ready.
      applyStimulus(1'b1, randData(), 1'b1, 1'b1, 1'b0);
      drain(2);

      // Clear during a push at level 10.
      fill(10);
      applyStimulus(1'b1, randData(), 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

      // Overflow by five beats, the last carrying tlast.
      fill(DEPTH);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, randData(), (i == 4), 1'b0, 1'b0);
      drain(DEPTH + 1);

      // Random traffic with varying rates and occasional flushes.
      for (int i = 0; i < 4000; i++) begin
         int vp;
         int rp;
         vp = (i / 500) % 4;
         rp = (i / 700) % 4;
         applyStimulus(($urandom_range(0, 3) <= vp), randData(), ($urandom_range(0, 4) == 0),
                       ($urandom_range(0, 3) <= rp), ($urandom_range(0, 299) == 0));
      end
      drain(DEPTH + 1);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
